id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Latches decoded operands and control from the decode stage.
- In the EX cycle, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, then drives the ALU's two source operands and operation code.
- Detects load-use hazards, inserts a bubble and holds decode; supports external stall and flush.

Parameters:
DATA_W, 32, operand/result width
REG_ADDR_W, 5, register index width
OP_W, 4, ALU operation code width

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
id_valid_i  in  1  decode slot holds a real instruction
id_rs_addr_i  in  REG_ADDR_W  rs index
id_rt_addr_i  in  REG_ADDR_W  rt index
id_wr_addr_i  in  REG_ADDR_W  destination index (already rd/rt-selected)
id_rs_data_i  in  DATA_W  register file rs value
id_rt_data_i  in  DATA_W  register file rt value
id_imm_i  in  DATA_W  sign/zero-extended immediate
id_uses_rt_i  in  1  instruction reads rt (R-type, store, branch)
id_alu_src_imm_i  in  1  ALU operand 2 = immediate
id_alu_op_i  in  OP_W  ALU operation code
id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i  in  1 each  control bits
stall_i  in  1  downstream hold
flush_i  in  1  squash (taken branch/jump)
exmem_reg_write_i  in  1  EX/MEM writes a register
exmem_wr_addr_i  in  REG_ADDR_W  EX/MEM destination
exmem_result_i  in  DATA_W  EX/MEM ALU result
memwb_reg_write_i  in  1  MEM/WB writes a register
memwb_wr_addr_i  in  REG_ADDR_W  MEM/WB destination
memwb_data_i  in  DATA_W  MEM/WB write-back value
alu_src1_o  out  DATA_W  forwarded rs operand
alu_src2_o  out  DATA_W  immediate or forwarded rt
alu_op_o  out  OP_W  registered ALU op
store_data_o  out  DATA_W  forwarded rt for stores
ex_wr_addr_o  out  REG_ADDR_W  registered destination
ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o  out  1 each  registered control
load_use_o  out  1  load-use hazard detected this cycle
id_hold_o  out  1  decode/PC must hold (= load_use_o | stall_i)

Behaviour:
- Reset: every register cleared to 0. ex_valid_o, all control bits and alu_op_o are 0. With forwarding inputs idle, alu_src1_o, alu_src2_o and store_data_o read 0.
- Next-state priority per edge:
  1. rst_i
  2. flush_i: load a bubble (all fields 0)
  3. stall_i: hold all fields
  4. load_use_o: load a bubble; decode holds via id_hold_o
  5. otherwise load the id_* fields
- Bubble = valid 0, reg_write/mem_read/mem_write/mem_to_reg 0, alu_op 0. Data fields are also zeroed.
- load_use_o (combinational) = id_valid_i & ex_valid_o & ex_mem_read_o & (ex_wr_addr_o != 0) & ((id_rs_addr_i == ex_wr_addr_o) | (id_uses_rt_i & id_rt_addr_i == ex_wr_addr_o)).
- Forwarding (combinational, on registered rs/rt, per operand):
  - EX/MEM wins if exmem_reg_write_i, exmem_wr_addr_i != 0 and the address matches.
  - Otherwise MEM/WB if memwb_reg_write_i, memwb_wr_addr_i != 0 and the address matches.
  - Otherwise the registered register-file value.
  - Register 0 is never forwarded.
- alu_src2_o = registered immediate when alu_src_imm is set, else forwarded rt. store_data_o is always forwarded rt.
- Latency: id_* inputs appear on the outputs 1 cycle after a load edge. Forwarding adds no cycles.
- A stalled instruction keeps re-evaluating forwarding every cycle, so operands track new EX/MEM and MEM/WB values.
- No arithmetic inside; widths pass straight through.

Test Plan:
- rst_i high 2 cycles mid-stream with nonzero id inputs -> all outputs 0, ex_valid_o 0; first edge after release loads id values.
- id rs=3 data 0x10, imm=0xFFFFFFFC, alu_src_imm=1, op=2 -> next cycle alu_src1_o=0x10, alu_src2_o=0xFFFFFFFC, alu_op_o=2.
- EX rs=5, rt=5; exmem wr 5 = 0xAAAA and memwb wr 5 = 0xBBBB both writing -> both operands 0xAAAA. Same with exmem wr 0 -> 0xBBBB. Both with wr_addr 0 -> register file value.
- EX holds lw to r8; decode add reads rs=8, id_valid_i=1 -> load_use_o=1 and id_hold_o=1; next cycle ex_valid_o=0 and controls 0. With id_uses_rt_i=0 and only rt=8 -> load_use_o=0.
- stall_i=1 for 3 cycles with changing id inputs -> EX fields unchanged. Change memwb_data_i for a matching address during the stall -> alu_src1_o follows it.
- flush_i and stall_i asserted together -> bubble loaded. flush_i during a load-use hazard -> bubble, and load_use_o clears the following cycle.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU. It resolves RAW hazards by forwarding
// from EX/MEM and MEM/WB, and bubbles the pipe on load-use hazards.
module id_ex_operand_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rt_addr_i,
    input  logic [REG_ADDR_W-1:0] id_wr_addr_i,
    input  logic [DATA_W-1:0]     id_rs_data_i,
    input  logic [DATA_W-1:0]     id_rt_data_i,
    input  logic [DATA_W-1:0]     id_imm_i,
    input  logic                  id_uses_rt_i,
    input  logic                  id_alu_src_imm_i,
    input  logic [OP_W-1:0]       id_alu_op_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_mem_read_i,
    input  logic                  id_mem_write_i,
    input  logic                  id_mem_to_reg_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  exmem_reg_write_i,
    input  logic [REG_ADDR_W-1:0] exmem_wr_addr_i,
    input  logic [DATA_W-1:0]     exmem_result_i,
    input  logic                  memwb_reg_write_i,
    input  logic [REG_ADDR_W-1:0] memwb_wr_addr_i,
    input  logic [DATA_W-1:0]     memwb_data_i,
    output logic [DATA_W-1:0]     alu_src1_o,
    output logic [DATA_W-1:0]     alu_src2_o,
    output logic [OP_W-1:0]       alu_op_o,
    output logic [DATA_W-1:0]     store_data_o,
    output logic [REG_ADDR_W-1:0] ex_wr_addr_o,
    output logic                  ex_valid_o,
    output logic                  ex_reg_write_o,
    output logic                  ex_mem_read_o,
    output logic                  ex_mem_write_o,
    output logic                  ex_mem_to_reg_o,
    output logic                  load_use_o,
    output logic                  id_hold_o
);

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  alu_src_imm;
        logic [OP_W-1:0]       alu_op;
        logic [REG_ADDR_W-1:0] rs_addr;
        logic [REG_ADDR_W-1:0] rt_addr;
        logic [REG_ADDR_W-1:0] wr_addr;
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     rt_data;
        logic [DATA_W-1:0]     imm;
    } ex_reg_t;

    ex_reg_t ex_q, ex_d;
    logic    load_use;

    // A load in EX cannot supply its data until MEM, so a dependent decode slot must wait.
    assign load_use = id_valid_i & ex_q.valid & ex_q.mem_read & (ex_q.wr_addr != '0)
                    & ((id_rs_addr_i == ex_q.wr_addr)
                       | (id_uses_rt_i & (id_rt_addr_i == ex_q.wr_addr)));

    always_comb begin
        // NOTE: hold is the default so every path assigns ex_d and no latch is inferred.
        ex_d = ex_q;
        if (flush_i) begin
            ex_d = '0;
        end else if (stall_i) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d = '0;
        end else begin
            ex_d.valid       = id_valid_i;
            ex_d.reg_write   = id_reg_write_i;
            ex_d.mem_read    = id_mem_read_i;
            ex_d.mem_write   = id_mem_write_i;
            ex_d.mem_to_reg  = id_mem_to_reg_i;
            ex_d.alu_src_imm = id_alu_src_imm_i;
            ex_d.alu_op      = id_alu_op_i;
            ex_d.rs_addr     = id_rs_addr_i;
            ex_d.rt_addr     = id_rt_addr_i;
            ex_d.wr_addr     = id_wr_addr_i;
            ex_d.rs_data     = id_rs_data_i;
            ex_d.rt_data     = id_rt_data_i;
            ex_d.imm         = id_imm_i;
        end
    end

    // NOTE: state registers use non-blocking assignments; reset is synchronous and clears every field.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // The address match excludes r0 because a write to r0 must never be observed.
    function automatic logic [DATA_W-1:0] forward(
        input logic [REG_ADDR_W-1:0] addr,
        input logic [DATA_W-1:0]     rf_data,
        input logic                  xm_we,
        input logic [REG_ADDR_W-1:0] xm_addr,
        input logic [DATA_W-1:0]     xm_data,
        input logic                  mw_we,
        input logic [REG_ADDR_W-1:0] mw_addr,
        input logic [DATA_W-1:0]     mw_data
    );
        if (xm_we && (xm_addr != '0) && (xm_addr == addr)) begin
            return xm_data;
        end else if (mw_we && (mw_addr != '0) && (mw_addr == addr)) begin
            return mw_data;
        end
        return rf_data;
    endfunction

    logic [DATA_W-1:0] fwd_rs, fwd_rt;

    always_comb begin
        fwd_rs = forward(ex_q.rs_addr, ex_q.rs_data, exmem_reg_write_i, exmem_wr_addr_i,
                         exmem_result_i, memwb_reg_write_i, memwb_wr_addr_i, memwb_data_i);
        fwd_rt = forward(ex_q.rt_addr, ex_q.rt_data, exmem_reg_write_i, exmem_wr_addr_i,
                         exmem_result_i, memwb_reg_write_i, memwb_wr_addr_i, memwb_data_i);
    end

    assign alu_src1_o      = fwd_rs;
    assign alu_src2_o      = ex_q.alu_src_imm ? ex_q.imm : fwd_rt;
    assign store_data_o    = fwd_rt;
    assign alu_op_o        = ex_q.alu_op;
    assign ex_wr_addr_o    = ex_q.wr_addr;
    assign ex_valid_o      = ex_q.valid;
    assign ex_reg_write_o  = ex_q.reg_write;
    assign ex_mem_read_o   = ex_q.mem_read;
    assign ex_mem_write_o  = ex_q.mem_write;
    assign ex_mem_to_reg_o = ex_q.mem_to_reg;
    assign load_use_o      = load_use;
    assign id_hold_o       = load_use | stall_i;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: a table of single-cycle vectors
// followed by hand-written reset, load-use, stall and flush sequences.
module tb_id_ex_operand_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs_addr_i, id_rt_addr_i, id_wr_addr_i;
    logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
    logic        id_uses_rt_i, id_alu_src_imm_i;
    logic [3:0]  id_alu_op_i;
    logic        id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i;
    logic        stall_i, flush_i;
    logic        exmem_reg_write_i;
    logic [4:0]  exmem_wr_addr_i;
    logic [31:0] exmem_result_i;
    logic        memwb_reg_write_i;
    logic [4:0]  memwb_wr_addr_i;
    logic [31:0] memwb_data_i;
    logic [31:0] alu_src1_o, alu_src2_o, store_data_o;
    logic [3:0]  alu_op_o;
    logic [4:0]  ex_wr_addr_o;
    logic        ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o;
    logic        load_use_o, id_hold_o;

    int tests = 0;
    int fails = 0;

    id_ex_operand_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i),
        .id_wr_addr_i(id_wr_addr_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
        .id_imm_i(id_imm_i), .id_uses_rt_i(id_uses_rt_i), .id_alu_src_imm_i(id_alu_src_imm_i),
        .id_alu_op_i(id_alu_op_i), .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
        .id_mem_write_i(id_mem_write_i), .id_mem_to_reg_i(id_mem_to_reg_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .exmem_reg_write_i(exmem_reg_write_i), .exmem_wr_addr_i(exmem_wr_addr_i),
        .exmem_result_i(exmem_result_i), .memwb_reg_write_i(memwb_reg_write_i),
        .memwb_wr_addr_i(memwb_wr_addr_i), .memwb_data_i(memwb_data_i),
        .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_op_o(alu_op_o),
        .store_data_o(store_data_o), .ex_wr_addr_o(ex_wr_addr_o), .ex_valid_o(ex_valid_o),
        .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o),
        .ex_mem_write_o(ex_mem_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
        .load_use_o(load_use_o), .id_hold_o(id_hold_o)
    );

    always #5 clk_i = ~clk_i;

    // ctrl packs {reg_write, mem_read, mem_write, mem_to_reg}.
    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, wr;
        logic [31:0] rs_data, rt_data, imm;
        logic        src_imm;
        logic [3:0]  op;
        logic [3:0]  ctrl;
        logic        xm_we;
        logic [4:0]  xm_addr;
        logic [31:0] xm_data;
        logic        mw_we;
        logic [4:0]  mw_addr;
        logic [31:0] mw_data;
        logic [31:0] e_src1, e_src2, e_store;
        logic [3:0]  e_op;
        logic [4:0]  e_wr;
        logic        e_valid;
        logic [3:0]  e_ctrl;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_id(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] wr, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic uses_rt, input logic src_imm,
                          input logic [3:0] op, input logic [3:0] ctrl);
        id_valid_i       = valid;
        id_rs_addr_i     = rs;
        id_rt_addr_i     = rt;
        id_wr_addr_i     = wr;
        id_rs_data_i     = rsd;
        id_rt_data_i     = rtd;
        id_imm_i         = imm;
        id_uses_rt_i     = uses_rt;
        id_alu_src_imm_i = src_imm;
        id_alu_op_i      = op;
        {id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i} = ctrl;
    endtask

    task automatic set_fwd(input logic xm_we, input logic [4:0] xm_addr, input logic [31:0] xm_data,
                           input logic mw_we, input logic [4:0] mw_addr, input logic [31:0] mw_data);
        exmem_reg_write_i = xm_we;
        exmem_wr_addr_i   = xm_addr;
        exmem_result_i    = xm_data;
        memwb_reg_write_i = mw_we;
        memwb_wr_addr_i   = mw_addr;
        memwb_data_i      = mw_data;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " src1"}, alu_src1_o, 32'h0);
        check({tag, " src2"}, alu_src2_o, 32'h0);
        check({tag, " store"}, store_data_o, 32'h0);
        check({tag, " op"}, alu_op_o, 32'h0);
        check({tag, " wr"}, ex_wr_addr_o, 32'h0);
        check({tag, " valid"}, ex_valid_o, 32'h0);
        check({tag, " ctrl"}, {ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o}, 32'h0);
        check({tag, " load_use"}, load_use_o, 32'h0);
    endtask

    vec_t vecs[8];

    initial begin
        // rs, rt, wr | rs_data, rt_data, imm | src_imm, op, ctrl | fwd | expected
        vecs[0] = '{1'b1, 5'd3, 5'd4, 5'd6, 32'h10, 32'h20, 32'hFFFF_FFFC, 1'b1, 4'd2, 4'b1000,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    32'h10, 32'hFFFF_FFFC, 32'h20, 4'd2, 5'd6, 1'b1, 4'b1000};
        vecs[1] = '{1'b1, 5'd5, 5'd5, 5'd7, 32'h11, 32'h22, 32'h0, 1'b0, 4'd3, 4'b1000,
                    1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB,
                    32'hAAAA, 32'hAAAA, 32'hAAAA, 4'd3, 5'd7, 1'b1, 4'b1000};
        vecs[2] = '{1'b1, 5'd5, 5'd5, 5'd7, 32'h11, 32'h22, 32'h0, 1'b0, 4'd3, 4'b1000,
                    1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB,
                    32'hBBBB, 32'hBBBB, 32'hBBBB, 4'd3, 5'd7, 1'b1, 4'b1000};
        vecs[3] = '{1'b1, 5'd5, 5'd5, 5'd7, 32'h11, 32'h22, 32'h0, 1'b0, 4'd3, 4'b1000,
                    1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB,
                    32'h11, 32'h22, 32'h22, 4'd3, 5'd7, 1'b1, 4'b1000};
        vecs[4] = '{1'b1, 5'd7, 5'd9, 5'd2, 32'h1, 32'h2, 32'h5, 1'b1, 4'd7, 4'b0010,
                    1'b0, 5'd7, 32'hCCCC, 1'b1, 5'd9, 32'hDDDD,
                    32'h1, 32'h5, 32'hDDDD, 4'd7, 5'd2, 1'b1, 4'b0010};
        vecs[5] = '{1'b1, 5'd0, 5'd0, 5'd1, 32'h33, 32'h44, 32'h0, 1'b0, 4'd6, 4'b1001,
                    1'b1, 5'd0, 32'hEEEE, 1'b1, 5'd0, 32'hFFFF,
                    32'h33, 32'h44, 32'h44, 4'd6, 5'd1, 1'b1, 4'b1001};
        vecs[6] = '{1'b0, 5'd1, 5'd2, 5'd3, 32'h55, 32'h66, 32'h0, 1'b0, 4'd1, 4'b0000,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    32'h55, 32'h66, 32'h66, 4'd1, 5'd3, 1'b0, 4'b0000};
        vecs[7] = '{1'b1, 5'd3, 5'd4, 5'd12, 32'h77, 32'h88, 32'h0, 1'b0, 4'd9, 4'b1000,
                    1'b1, 5'd3, 32'h1234, 1'b1, 5'd4, 32'h5678,
                    32'h1234, 32'h5678, 32'h5678, 4'd9, 5'd12, 1'b1, 4'b1000};

        rst_i   = 1'b1;
        stall_i = 1'b0;
        flush_i = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 5'd3, 5'd4, 5'd6, 32'h99, 32'h98, 32'h97, 1'b1, 1'b0, 4'd5, 4'b1111);
        step();
        step();
        check_zero("reset");
        rst_i = 1'b0;

        // Table: each vector is one load edge followed by a comparison of every output.
        foreach (vecs[i]) begin
            set_id(vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].wr, vecs[i].rs_data,
                   vecs[i].rt_data, vecs[i].imm, 1'b1, vecs[i].src_imm, vecs[i].op, vecs[i].ctrl);
            set_fwd(vecs[i].xm_we, vecs[i].xm_addr, vecs[i].xm_data,
                    vecs[i].mw_we, vecs[i].mw_addr, vecs[i].mw_data);
            step();
            check($sformatf("vec%0d src1", i), alu_src1_o, vecs[i].e_src1);
            check($sformatf("vec%0d src2", i), alu_src2_o, vecs[i].e_src2);
            check($sformatf("vec%0d store", i), store_data_o, vecs[i].e_store);
            check($sformatf("vec%0d op", i), alu_op_o, vecs[i].e_op);
            check($sformatf("vec%0d wr", i), ex_wr_addr_o, vecs[i].e_wr);
            check($sformatf("vec%0d valid", i), ex_valid_o, vecs[i].e_valid);
            check($sformatf("vec%0d ctrl", i),
                  {ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o}, vecs[i].e_ctrl);
        end
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Load-use on rs: lw r8 in EX, add reading r8 in decode.
        set_id(1'b1, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 4'd0, 4'b1101);
        step();
        check("lw in ex mem_read", ex_mem_read_o, 32'h1);
        set_id(1'b1, 5'd8, 5'd2, 5'd10, 32'h3, 32'h4, 32'h0, 1'b1, 1'b0, 4'd5, 4'b1000);
        #1;
        check("lu rs load_use", load_use_o, 32'h1);
        check("lu rs hold", id_hold_o, 32'h1);
        step();
        check("bubble valid", ex_valid_o, 32'h0);
        check("bubble ctrl", {ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o}, 32'h0);
        check("bubble op", alu_op_o, 32'h0);
        check("bubble load_use clear", load_use_o, 32'h0);
        check("bubble hold clear", id_hold_o, 32'h0);
        step();
        check("add after bubble valid", ex_valid_o, 32'h1);
        check("add after bubble op", alu_op_o, 32'h5);
        check("add after bubble wr", ex_wr_addr_o, 32'd10);

        // Load-use on rt only matters when the instruction reads rt.
        set_id(1'b1, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 4'd0, 4'b1101);
        step();
        set_id(1'b1, 5'd1, 5'd8, 5'd10, 32'h3, 32'h4, 32'h0, 1'b0, 1'b1, 4'd5, 4'b1000);
        #1;
        check("lu rt unused", load_use_o, 32'h0);
        id_uses_rt_i = 1'b1;
        #1;
        check("lu rt used", load_use_o, 32'h1);
        id_valid_i = 1'b0;
        #1;
        check("lu id invalid", load_use_o, 32'h0);
        id_valid_i = 1'b1;
        #1;

        // Flush during load-use: bubble loaded and the hazard disappears.
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1;
        check("flush lu valid", ex_valid_o, 32'h0);
        check("flush lu mem_read", ex_mem_read_o, 32'h0);
        check("flush lu load_use", load_use_o, 32'h0);

        // Load from r0 never creates a hazard.
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 4'd0, 4'b0101);
        step();
        set_id(1'b1, 5'd0, 5'd0, 5'd10, 32'h3, 32'h4, 32'h0, 1'b1, 1'b0, 4'd5, 4'b1000);
        #1;
        check("lu r0", load_use_o, 32'h0);

        // Stall: EX fields frozen while decode changes; forwarding still tracks.
        set_id(1'b1, 5'd3, 5'd4, 5'd9, 32'h100, 32'h200, 32'h0, 1'b1, 1'b0, 4'd4, 4'b1000);
        step();
        stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            set_id(1'b1, 5'(c + 11), 5'(c + 14), 5'(c + 20), 32'(c + 1), 32'(c + 2), 32'h0,
                   1'b1, 1'b1, 4'(c + 10), 4'b0010);
            step();
            check($sformatf("stall%0d src1", c), alu_src1_o, 32'h100);
            check($sformatf("stall%0d op", c), alu_op_o, 32'h4);
            check($sformatf("stall%0d wr", c), ex_wr_addr_o, 32'd9);
            check($sformatf("stall%0d hold", c), id_hold_o, 32'h1);
        end
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h500);
        #1;
        check("stall fwd memwb", alu_src1_o, 32'h500);
        step();
        memwb_data_i = 32'h600;
        #1;
        check("stall fwd memwb new", alu_src1_o, 32'h600);
        set_fwd(1'b1, 5'd3, 32'h700, 1'b1, 5'd3, 32'h600);
        #1;
        check("stall fwd exmem", alu_src1_o, 32'h700);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Flush and stall together: flush wins.
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        stall_i = 1'b0;
        #1;
        check("flush+stall valid", ex_valid_o, 32'h0);
        check("flush+stall op", alu_op_o, 32'h0);
        check("flush+stall src1", alu_src1_o, 32'h0);
        check("flush+stall wr", ex_wr_addr_o, 32'h0);

        // Mid-stream reset with live decode inputs, then first load after release.
        set_id(1'b1, 5'd6, 5'd7, 5'd11, 32'hABCD, 32'h1357, 32'h0, 1'b1, 1'b0, 4'd8, 4'b1000);
        step();
        check("pre-reset valid", ex_valid_o, 32'h1);
        rst_i = 1'b1;
        step();
        step();
        check_zero("midreset");
        rst_i = 1'b0;
        step();
        check("post-reset src1", alu_src1_o, 32'hABCD);
        check("post-reset src2", alu_src2_o, 32'h1357);
        check("post-reset op", alu_op_o, 32'h8);
        check("post-reset valid", ex_valid_o, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
